// File: rtl/lb_bus_arbiter_if.sv
// Local-bus arbitration handshake between the 68040, the DMA master and the arbiter.
// The master modport is the arbiter side; the slave modport is the requesting agents and the wired BB.
interface lb_bus_arbiter_if;
    logic BR_CPUn;
    logic LOCK_CPUn;
    logic BB_BUSn;
    logic DMA_REQn;
    logic BG_CPUn;
    logic DMA_GNTn;
    logic OWNER;
    logic ARB_ERR;

    modport master (
        input  BR_CPUn, LOCK_CPUn, BB_BUSn, DMA_REQn,
        output BG_CPUn, DMA_GNTn, OWNER, ARB_ERR
    );

    modport slave (
        output BR_CPUn, LOCK_CPUn, BB_BUSn, DMA_REQn,
        input  BG_CPUn, DMA_GNTn, OWNER, ARB_ERR
    );
endinterface

// File: rtl/lb_bus_arbiter.sv
// 68040 local-bus arbiter: bus parked on the CPU, one secondary (DMA) master, BR/BG/BB handshake.
// Optional DMA tenure limit with CPU preemption is enabled by defining ARB_DMA_LIMIT_EN.
module lb_bus_arbiter #(
    parameter int GRANT_TIMEOUT  = 16,
    parameter int CPU_MIN_HOLD   = 8,
    parameter int DMA_MAX_TENURE = 64,
    parameter int CNT_W          = 7
) (
    input  logic              CLK40,
    input  logic              RESETn,
    lb_bus_arbiter_if.master  bus
);
    typedef enum logic [2:0] {
        CPU_PARK    = 3'd0,
        CPU_RELEASE = 3'd1,
        DMA_GRANT   = 3'd2,
        DMA_OWN     = 3'd3,
`ifdef ARB_DMA_LIMIT_EN
        DMA_PREEMPT = 3'd4,
`endif
        CPU_RETURN  = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             err_d;
    logic             bg_d, gnt_d, owner_d;
    logic             bg_q, gnt_q, owner_q, err_q;

`ifndef ARB_DMA_LIMIT_EN
    localparam int unused_tenure = DMA_MAX_TENURE;
`endif

    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_inc;
        err_d   = 1'b0;
        case (state_q)
            CPU_PARK:
                if (!bus.DMA_REQn && bus.LOCK_CPUn &&
                    (cnt_q >= CNT_W'(CPU_MIN_HOLD) || bus.BR_CPUn))
                    state_d = CPU_RELEASE;
            // Counter holds the run length of released-BB samples here.
            CPU_RELEASE:
                if (bus.DMA_REQn)          state_d = CPU_PARK;
                else if (!bus.BB_BUSn)     cnt_d   = '0;
                else if (cnt_q != '0)      state_d = DMA_GRANT;
            DMA_GRANT:
                if (!bus.BB_BUSn)          state_d = DMA_OWN;
                else if (bus.DMA_REQn)     state_d = CPU_RETURN;
                else if (cnt_q >= CNT_W'(GRANT_TIMEOUT - 1)) begin
                    state_d = CPU_RETURN;
                    err_d   = 1'b1;
                end
            DMA_OWN:
                if (bus.DMA_REQn && bus.BB_BUSn) state_d = CPU_RETURN;
`ifdef ARB_DMA_LIMIT_EN
                else if (!bus.BR_CPUn && cnt_q >= CNT_W'(DMA_MAX_TENURE - 1))
                    state_d = DMA_PREEMPT;
            DMA_PREEMPT:
                if (bus.BB_BUSn) state_d = CPU_RETURN;
`endif
            // Entry clock is the idle clock; leave once BB is seen released.
            CPU_RETURN:
                if (bus.BB_BUSn) state_d = CPU_PARK;
            default:
                state_d = CPU_PARK;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    always_comb begin
        bg_d    = 1'b1;
        gnt_d   = 1'b1;
        owner_d = 1'b0;
        case (state_d)
            CPU_PARK:  bg_d = 1'b0;
            DMA_GRANT,
            DMA_OWN: begin
                gnt_d   = 1'b0;
                owner_d = 1'b1;
            end
`ifdef ARB_DMA_LIMIT_EN
            DMA_PREEMPT: owner_d = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge CLK40) begin
        if (!RESETn) begin
            state_q <= CPU_PARK;
            cnt_q   <= '0;
            bg_q    <= 1'b0;
            gnt_q   <= 1'b1;
            owner_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bg_q    <= bg_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            err_q   <= err_d;
        end
    end

    assign bus.BG_CPUn  = bg_q;
    assign bus.DMA_GNTn = gnt_q;
    assign bus.OWNER    = owner_q;
    assign bus.ARB_ERR  = err_q;
endmodule

// File: tb/tb_lb_bus_arbiter.sv
// Scenario bench for lb_bus_arbiter: randomized timing, expected cycle counts derived from the arbitration rules.
`timescale 1ns/1ps
module tb_lb_bus_arbiter;
    localparam int GRANT_TIMEOUT  = 16;
    localparam int CPU_MIN_HOLD   = 8;
    localparam int DMA_MAX_TENURE = 64;

    // Output vector {BG_CPUn, DMA_GNTn, OWNER, ARB_ERR} per ownership phase.
    localparam logic [3:0] V_PARK    = 4'b0100;
    localparam logic [3:0] V_HANDOFF = 4'b1100;
    localparam logic [3:0] V_DMA     = 4'b1010;
    localparam logic [3:0] V_PREEMPT = 4'b1110;
    localparam logic [3:0] V_ERR     = 4'b1101;

    logic CLK40  = 1'b0;
    logic RESETn = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    logic rst_at_edge = 1'b1;

    lb_bus_arbiter_if bus();

    lb_bus_arbiter #(
        .GRANT_TIMEOUT (GRANT_TIMEOUT),
        .CPU_MIN_HOLD  (CPU_MIN_HOLD),
        .DMA_MAX_TENURE(DMA_MAX_TENURE),
        .CNT_W         (7)
    ) dut (
        .CLK40 (CLK40),
        .RESETn(RESETn),
        .bus   (bus)
    );

    always #10 CLK40 = ~CLK40;

    function automatic logic [3:0] outs();
        return {bus.BG_CPUn, bus.DMA_GNTn, bus.OWNER, bus.ARB_ERR};
    endfunction

    task automatic step();
        @(posedge CLK40);
        #1;
    endtask

    initial forever begin
        @(posedge CLK40);
        rst_at_edge = !RESETn;
    end

    // Grant exclusivity every clock, plus a both-high clock between owners outside reset.
    initial begin
        logic prev_bg_low, prev_gnt_low;
        prev_bg_low  = 1'b0;
        prev_gnt_low = 1'b0;
        forever begin
            @(negedge CLK40);
            checks++;
            if (bus.BG_CPUn === 1'b0 && bus.DMA_GNTn === 1'b0) begin
                failures++;
                $display("FAIL grant_overlap t=%0t got BG_CPUn=0 DMA_GNTn=0 want not both 0", $time);
            end
            if (!rst_at_edge) begin
                checks++;
                if ((prev_gnt_low && bus.BG_CPUn === 1'b0) || (prev_bg_low && bus.DMA_GNTn === 1'b0)) begin
                    failures++;
                    $display("FAIL handoff_gap t=%0t got direct owner swap want idle clock", $time);
                end
            end
            prev_bg_low  = (bus.BG_CPUn === 1'b0);
            prev_gnt_low = (bus.DMA_GNTn === 1'b0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic acquire();
        int lat;
        bus.DMA_REQn = 1'b0; bus.BR_CPUn = 1'b1; bus.LOCK_CPUn = 1'b1; bus.BB_BUSn = 1'b1;
        lat = 0;
        while (bus.DMA_GNTn !== 1'b0 && lat < 20) begin step(); lat++; end
        checks++;
        if (lat != 3) begin failures++; $display("FAIL acquire_latency got=%0d want=3", lat); end
    endtask

    task automatic test_reset();
        RESETn = 1'b0;
        bus.DMA_REQn = 1'b0; bus.BR_CPUn = 1'b1; bus.LOCK_CPUn = 1'b1; bus.BB_BUSn = 1'b1;
        repeat (3) step();
        checks++; if (outs() !== V_PARK) begin failures++; $display("FAIL reset_hold got=%b want=%b", outs(), V_PARK); end
        RESETn = 1'b1;
        step();
        checks++; if (outs() !== V_HANDOFF) begin failures++; $display("FAIL reset_release_bg got=%b want=%b", outs(), V_HANDOFF); end
        step();
        checks++; if (outs() !== V_HANDOFF) begin failures++; $display("FAIL reset_bb_wait got=%b want=%b", outs(), V_HANDOFF); end
        step();
        checks++; if (outs() !== V_DMA) begin failures++; $display("FAIL reset_grant got=%b want=%b", outs(), V_DMA); end
        bus.DMA_REQn = 1'b1;
        step();
        checks++; if (outs() !== V_HANDOFF) begin failures++; $display("FAIL grant_withdraw got=%b want=%b", outs(), V_HANDOFF); end
        step();
        checks++; if (outs() !== V_PARK) begin failures++; $display("FAIL withdraw_park got=%b want=%b", outs(), V_PARK); end
    endtask

    task automatic test_lock();
        int n;
        n = $urandom_range(20, 30);
        bus.LOCK_CPUn = 1'b0; bus.BR_CPUn = 1'b0; bus.BB_BUSn = 1'b0; bus.DMA_REQn = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            checks++; if (outs() !== V_PARK) begin failures++; $display("FAIL lock_hold clk=%0d got=%b want=%b", i, outs(), V_PARK); end
        end
        bus.LOCK_CPUn = 1'b1; bus.BR_CPUn = 1'($urandom_range(0, 1)); bus.BB_BUSn = 1'b1;
        step();
        checks++; if (outs() !== V_HANDOFF) begin failures++; $display("FAIL lock_release_bg got=%b want=%b", outs(), V_HANDOFF); end
        step();
        step();
        checks++; if (outs() !== V_DMA) begin failures++; $display("FAIL lock_grant got=%b want=%b", outs(), V_DMA); end
        bus.DMA_REQn = 1'b1;
        step();
        step();
        checks++; if (outs() !== V_PARK) begin failures++; $display("FAIL lock_park got=%b want=%b", outs(), V_PARK); end
    endtask

    task automatic test_timeout();
        int w;
        acquire();
        for (int k = 1; k < GRANT_TIMEOUT; k++) begin
            step();
            checks++; if (outs() !== V_DMA) begin failures++; $display("FAIL grant_wait clk=%0d got=%b want=%b", k, outs(), V_DMA); end
        end
        step();
        checks++; if (outs() !== V_ERR) begin failures++; $display("FAIL timeout_err got=%b want=%b", outs(), V_ERR); end
        // Previous owner still finishing: BB held low in the return phase.
        w = $urandom_range(1, 4);
        bus.BB_BUSn = 1'b0; bus.DMA_REQn = 1'b1;
        for (int i = 0; i < w; i++) begin
            step();
            checks++; if (outs() !== V_HANDOFF) begin failures++; $display("FAIL return_wait clk=%0d got=%b want=%b", i, outs(), V_HANDOFF); end
        end
        bus.BB_BUSn = 1'b1;
        step();
        checks++; if (outs() !== V_PARK) begin failures++; $display("FAIL timeout_park got=%b want=%b", outs(), V_PARK); end
    endtask

    task automatic test_own_release();
        int t, d;
        acquire();
        bus.BB_BUSn = 1'b0;
        t = $urandom_range(1, 40);
        for (int i = 0; i <= t; i++) begin
            step();
            bus.BR_CPUn = 1'($urandom_range(0, 1));
            checks++; if (outs() !== V_DMA) begin failures++; $display("FAIL own_hold clk=%0d got=%b want=%b", i, outs(), V_DMA); end
        end
        d = $urandom_range(0, 3);
        bus.DMA_REQn = 1'b1;
        for (int i = 0; i < d; i++) begin
            step();
            checks++; if (outs() !== V_DMA) begin failures++; $display("FAIL own_bb_busy clk=%0d got=%b want=%b", i, outs(), V_DMA); end
        end
        bus.BB_BUSn = 1'b1;
        step();
        checks++; if (outs() !== V_HANDOFF) begin failures++; $display("FAIL own_release got=%b want=%b", outs(), V_HANDOFF); end
        step();
        checks++; if (outs() !== V_PARK) begin failures++; $display("FAIL own_park got=%b want=%b", outs(), V_PARK); end
    endtask

    task automatic test_min_hold();
        int hold;
        acquire();
        bus.BB_BUSn = 1'b0;
        step();
        bus.DMA_REQn = 1'b1; bus.BB_BUSn = 1'b1;
        step();
        step();
        checks++; if (outs() !== V_PARK) begin failures++; $display("FAIL min_hold_park got=%b want=%b", outs(), V_PARK); end
        bus.BR_CPUn = 1'b0; bus.DMA_REQn = 1'b0; bus.BB_BUSn = 1'b0;
        hold = 1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.BG_CPUn !== 1'b0) break;
            hold++;
        end
        checks++;
        if (hold < CPU_MIN_HOLD || hold > CPU_MIN_HOLD + 1) begin
            failures++; $display("FAIL min_hold got=%0d clocks want=%0d..%0d", hold, CPU_MIN_HOLD, CPU_MIN_HOLD + 1);
        end
        bus.DMA_REQn = 1'b1;
        step();
        checks++; if (outs() !== V_PARK) begin failures++; $display("FAIL release_abort got=%b want=%b", outs(), V_PARK); end
    endtask

    task automatic test_tenure();
        acquire();
        bus.BB_BUSn = 1'b0;
        step();
        bus.BR_CPUn = 1'b0;
`ifdef ARB_DMA_LIMIT_EN
        begin
            int r;
            for (int k = 1; k < DMA_MAX_TENURE; k++) begin
                step();
                checks++; if (outs() !== V_DMA) begin failures++; $display("FAIL tenure_hold clk=%0d got=%b want=%b", k, outs(), V_DMA); end
            end
            step();
            checks++; if (outs() !== V_PREEMPT) begin failures++; $display("FAIL tenure_preempt got=%b want=%b", outs(), V_PREEMPT); end
            bus.DMA_REQn = 1'b1;
            r = $urandom_range(1, 5);
            for (int i = 0; i < r; i++) begin
                step();
                checks++; if (outs() !== V_PREEMPT) begin failures++; $display("FAIL preempt_wait clk=%0d got=%b want=%b", i, outs(), V_PREEMPT); end
            end
            bus.BB_BUSn = 1'b1;
        end
`else
        for (int k = 1; k <= 200; k++) begin
            step();
            checks++; if (outs() !== V_DMA) begin failures++; $display("FAIL tenure_unbounded clk=%0d got=%b want=%b", k, outs(), V_DMA); end
        end
        bus.DMA_REQn = 1'b1; bus.BB_BUSn = 1'b1;
`endif
        step();
        checks++; if (outs() !== V_HANDOFF) begin failures++; $display("FAIL tenure_return got=%b want=%b", outs(), V_HANDOFF); end
        step();
        checks++; if (outs() !== V_PARK) begin failures++; $display("FAIL tenure_park got=%b want=%b", outs(), V_PARK); end
    endtask

    // DMA asserts BB after a random delay d; a timeout is expected exactly when d >= GRANT_TIMEOUT.
    task automatic test_back_to_back();
        for (int it = 0; it < 8; it++) begin
            int  d;
            bit  exp_err;
            logic [3:0] want;
            d = ($urandom_range(0, 1) != 0) ? $urandom_range(10, 14) : $urandom_range(16, 19);
            exp_err = (d >= GRANT_TIMEOUT);
            acquire();
            for (int k = 1; k <= GRANT_TIMEOUT + 2; k++) begin
                bus.BB_BUSn = (k <= d);
                step();
                want = (exp_err && k == GRANT_TIMEOUT) ? V_ERR : V_DMA;
                checks++;
                if (outs() !== want) begin failures++; $display("FAIL b2b_grant it=%0d d=%0d clk=%0d got=%b want=%b", it, d, k, outs(), want); end
                if (exp_err && k == GRANT_TIMEOUT) break;
            end
            bus.DMA_REQn = 1'b1; bus.BB_BUSn = 1'b1;
            if (!exp_err) begin
                step();
                checks++; if (outs() !== V_HANDOFF) begin failures++; $display("FAIL b2b_release it=%0d got=%b want=%b", it, outs(), V_HANDOFF); end
            end
            step();
            checks++; if (outs() !== V_PARK) begin failures++; $display("FAIL b2b_park it=%0d got=%b want=%b", it, outs(), V_PARK); end
        end
    endtask

    task automatic test_reset_mid();
        acquire();
        bus.BB_BUSn = 1'b0;
        step();
        RESETn = 1'b0;
        step();
        checks++; if (outs() !== V_PARK) begin failures++; $display("FAIL reset_mid got=%b want=%b", outs(), V_PARK); end
        RESETn = 1'b1; bus.DMA_REQn = 1'b1; bus.BB_BUSn = 1'b1;
        step();
        checks++; if (outs() !== V_PARK) begin failures++; $display("FAIL reset_mid_idle got=%b want=%b", outs(), V_PARK); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_timeout();
        test_own_release();
        test_min_hold();
        test_tenure();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
